// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame loader: parser states,
// default sync marker and header field widths.
package uart_frame_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_W     = 16;
    localparam int HDR_ADDR_W = 16;
    localparam int HDR_LEN_W  = 16;

    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CHK
    } state_t;

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte watchdog: reloads on every accepted byte, counts down while a
// frame is open, and flags expiry when the budget is exhausted with no byte.
module uart_frame_timeout #(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear_in,
    input  logic enable_in,
    output logic expire_out
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VALUE = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] remaining_q;
    logic [CW-1:0] remaining_d;

    // An arriving byte takes priority over an expiry in the same cycle.
    always_comb begin
        remaining_d = remaining_q;
        expire_out  = 1'b0;
        if (clear_in) begin
            remaining_d = LOAD_VALUE;
        end else if (!enable_in) begin
            remaining_d = '0;
        end else if (remaining_q == '0) begin
            expire_out = 1'b1;
        end else begin
            remaining_d = remaining_q - CW'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            remaining_q <= '0;
        end else begin
            remaining_q <= remaining_d;
        end
    end

endmodule

// File: rtl/uart_frame_loader.sv
// Parses SYNC/ADDR/LEN/DATA/CHK frames from a UART byte stream into 16-bit
// memory writes, with XOR checksum validation and inter-byte timeout.
module uart_frame_loader
    import uart_frame_pkg::*;
#(
    parameter int                ADDR_WIDTH     = 16,
    parameter logic [BYTE_W-1:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int                TIMEOUT_CYCLES = 200000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  byte_valid_in,
    input  logic [BYTE_W-1:0]     byte_in,
    output logic                  wr_en_out,
    output logic [ADDR_WIDTH-1:0] wr_addr_out,
    output logic [WORD_W-1:0]     wr_data_out,
    output logic                  frame_done_out,
    output logic                  frame_error_out,
    output logic                  busy_out,
    output logic [7:0]            frame_count_out
);

    state_t                  state_q,       state_d;
    logic [BYTE_W-1:0]       addr_hi_q,     addr_hi_d;
    logic [BYTE_W-1:0]       len_hi_q,      len_hi_d;
    logic [BYTE_W-1:0]       data_hi_q,     data_hi_d;
    logic [BYTE_W-1:0]       chk_q,         chk_d;
    logic [HDR_LEN_W-1:0]    remaining_q,   remaining_d;
    logic [ADDR_WIDTH-1:0]   next_addr_q,   next_addr_d;
    logic                    wr_en_q,       wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q,     wr_addr_d;
    logic [WORD_W-1:0]       wr_data_q,     wr_data_d;
    logic                    done_q,        done_d;
    logic                    error_q,       error_d;
    logic [7:0]              frame_count_q, frame_count_d;

    logic                    timeout_expire;
    logic [HDR_ADDR_W-1:0]   hdr_addr;
    logic [HDR_LEN_W-1:0]    hdr_len;

    assign hdr_addr = {addr_hi_q, byte_in};
    assign hdr_len  = {len_hi_q, byte_in};

    uart_frame_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clear_in  (byte_valid_in),
        .enable_in (state_q != IDLE),
        .expire_out(timeout_expire)
    );

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        addr_hi_d     = addr_hi_q;
        len_hi_d      = len_hi_q;
        data_hi_d     = data_hi_q;
        chk_d         = chk_q;
        remaining_d   = remaining_q;
        next_addr_d   = next_addr_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_count_d = frame_count_q;
        wr_en_d       = 1'b0;
        done_d        = 1'b0;
        error_d       = 1'b0;

        if (byte_valid_in) begin
            unique case (state_q)
                IDLE: begin
                    if (byte_in == SYNC_BYTE) begin
                        state_d = ADDR_HI;
                        chk_d   = '0;
                    end
                end
                ADDR_HI: begin
                    addr_hi_d = byte_in;
                    chk_d     = chk_q ^ byte_in;
                    state_d   = ADDR_LO;
                end
                ADDR_LO: begin
                    next_addr_d = ADDR_WIDTH'(hdr_addr);
                    chk_d       = chk_q ^ byte_in;
                    state_d     = LEN_HI;
                end
                LEN_HI: begin
                    len_hi_d = byte_in;
                    chk_d    = chk_q ^ byte_in;
                    state_d  = LEN_LO;
                end
                LEN_LO: begin
                    remaining_d = hdr_len;
                    chk_d       = chk_q ^ byte_in;
                    state_d     = (hdr_len == '0) ? CHK : DATA_HI;
                end
                DATA_HI: begin
                    data_hi_d = byte_in;
                    chk_d     = chk_q ^ byte_in;
                    state_d   = DATA_LO;
                end
                DATA_LO: begin
                    // Words commit immediately; a later bad checksum cannot undo them.
                    wr_en_d     = 1'b1;
                    wr_addr_d   = next_addr_q;
                    wr_data_d   = {data_hi_q, byte_in};
                    next_addr_d = next_addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - HDR_LEN_W'(1);
                    chk_d       = chk_q ^ byte_in;
                    state_d     = (remaining_q == HDR_LEN_W'(1)) ? CHK : DATA_HI;
                end
                CHK: begin
                    if (byte_in == chk_q) begin
                        done_d        = 1'b1;
                        frame_count_d = frame_count_q + 8'd1;
                    end else begin
                        error_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout_expire) begin
            error_d = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (rst_in) begin
            state_q       <= IDLE;
            addr_hi_q     <= '0;
            len_hi_q      <= '0;
            data_hi_q     <= '0;
            chk_q         <= '0;
            remaining_q   <= '0;
            next_addr_q   <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            addr_hi_q     <= addr_hi_d;
            len_hi_q      <= len_hi_d;
            data_hi_q     <= data_hi_d;
            chk_q         <= chk_d;
            remaining_q   <= remaining_d;
            next_addr_q   <= next_addr_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            done_q        <= done_d;
            error_q       <= error_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign wr_en_out       = wr_en_q;
    assign wr_addr_out     = wr_addr_q;
    assign wr_data_out     = wr_data_q;
    assign frame_done_out  = done_q;
    assign frame_error_out = error_q;
    assign busy_out        = (state_q != IDLE);
    assign frame_count_out = frame_count_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader: expected writes are queued as frames
// are driven and popped by a monitor as wr_en_out pulses.
module tb_uart_frame_loader;

    localparam int AW = 16;
    localparam int TO = 50;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          byte_valid_in = 1'b0;
    logic [7:0]    byte_in = 8'h00;
    logic          wr_en_out;
    logic [AW-1:0] wr_addr_out;
    logic [15:0]   wr_data_out;
    logic          frame_done_out;
    logic          frame_error_out;
    logic          busy_out;
    logic [7:0]    frame_count_out;

    always #5 clk_in = ~clk_in;

    uart_frame_loader #(
        .ADDR_WIDTH    (AW),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .byte_valid_in  (byte_valid_in),
        .byte_in        (byte_in),
        .wr_en_out      (wr_en_out),
        .wr_addr_out    (wr_addr_out),
        .wr_data_out    (wr_data_out),
        .frame_done_out (frame_done_out),
        .frame_error_out(frame_error_out),
        .busy_out       (busy_out),
        .frame_count_out(frame_count_out)
    );

    typedef logic [7:0] bytes_t[$];
    typedef logic [31:0] wr_t;

    wr_t        exp_q[$];
    wr_t        mon_exp;
    int         errors = 0;
    int         checks = 0;
    int         done_seen = 0;
    int         err_seen = 0;
    logic [7:0] exp_count = 8'd0;

    always @(negedge clk_in) begin
        if (wr_en_out) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, expected no write",
                         wr_addr_out, wr_data_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({wr_addr_out, wr_data_out} !== mon_exp) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                             wr_addr_out, wr_data_out, mon_exp[31:16], mon_exp[15:0]);
                end
            end
        end
        if (frame_done_out)  done_seen++;
        if (frame_error_out) err_seen++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk_in); #1;
        byte_valid_in = 1'b1;
        byte_in       = b;
        @(posedge clk_in); #1;
        byte_valid_in = 1'b0;
        repeat (3) @(posedge clk_in);
    endtask

    task automatic send_bytes(input bytes_t bs);
        foreach (bs[i]) send_byte(bs[i]);
    endtask

    function automatic logic [7:0] xor_of(input bytes_t bs);
        logic [7:0] acc = 8'h00;
        foreach (bs[i]) acc = acc ^ bs[i];
        return acc;
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk_in);
        checks++;
        if ({wr_en_out, wr_addr_out, wr_data_out, frame_done_out, frame_error_out,
             frame_count_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b addr=%h data=%h done=%b err=%b cnt=%h, expected all 0",
                     wr_en_out, wr_addr_out, wr_data_out, frame_done_out, frame_error_out,
                     frame_count_out);
        end
        checks++;
        if (busy_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b, expected 0", busy_out);
        end
        @(posedge clk_in); #1;
        rst_in = 1'b0;
    endtask

    task automatic test_good_frame();
        bytes_t f;
        int d0, e0;
        d0 = done_seen;
        e0 = err_seen;
        exp_q.push_back({16'h0010, 16'h1234});
        exp_q.push_back({16'h0011, 16'h5678});
        f = {8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h1A};
        send_bytes(f);
        exp_count = exp_count + 8'd1;
        repeat (2) @(negedge clk_in);
        checks++;
        if (done_seen - d0 !== 1 || err_seen - e0 !== 0) begin
            errors++;
            $display("FAIL good_pulses: got done=%0d err=%0d, expected done=1 err=0",
                     done_seen - d0, err_seen - e0);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL good_writes_missing: got %0d pending, expected 0", exp_q.size());
        end
        checks++;
        if (frame_count_out !== exp_count) begin
            errors++;
            $display("FAIL good_count: got %0d, expected %0d", frame_count_out, exp_count);
        end
        checks++;
        if (wr_addr_out !== 16'h0011 || wr_data_out !== 16'h5678) begin
            errors++;
            $display("FAIL good_hold: got addr=%h data=%h, expected 0011/5678",
                     wr_addr_out, wr_data_out);
        end
        checks++;
        if (busy_out !== 1'b0) begin
            errors++;
            $display("FAIL good_busy: got %b, expected 0", busy_out);
        end
    endtask

    task automatic test_bad_checksum();
        bytes_t f;
        int d0, e0;
        d0 = done_seen;
        e0 = err_seen;
        exp_q.push_back({16'h0010, 16'h1234});
        exp_q.push_back({16'h0011, 16'h5678});
        f = {8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h1B};
        send_bytes(f);
        repeat (2) @(negedge clk_in);
        checks++;
        if (done_seen - d0 !== 0 || err_seen - e0 !== 1) begin
            errors++;
            $display("FAIL badchk_pulses: got done=%0d err=%0d, expected done=0 err=1",
                     done_seen - d0, err_seen - e0);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL badchk_writes_missing: got %0d pending, expected 0", exp_q.size());
        end
        checks++;
        if (frame_count_out !== exp_count) begin
            errors++;
            $display("FAIL badchk_count: got %0d, expected %0d", frame_count_out, exp_count);
        end
    endtask

    task automatic test_zero_len_garbage();
        bytes_t g;
        bytes_t f;
        int d0, e0;
        d0 = done_seen;
        e0 = err_seen;
        g = {8'h00, 8'hFF, 8'h12};
        foreach (g[i]) begin
            send_byte(g[i]);
            checks++;
            if (busy_out !== 1'b0) begin
                errors++;
                $display("FAIL garbage_busy: got %b after byte %h, expected 0", busy_out, g[i]);
            end
        end
        f = {8'hA5, 8'h12, 8'h34, 8'h00, 8'h00, 8'h26};
        send_bytes(f);
        exp_count = exp_count + 8'd1;
        repeat (2) @(negedge clk_in);
        checks++;
        if (done_seen - d0 !== 1 || err_seen - e0 !== 0) begin
            errors++;
            $display("FAIL zerolen_pulses: got done=%0d err=%0d, expected done=1 err=0",
                     done_seen - d0, err_seen - e0);
        end
        checks++;
        if (frame_count_out !== exp_count) begin
            errors++;
            $display("FAIL zerolen_count: got %0d, expected %0d", frame_count_out, exp_count);
        end
    endtask

    task automatic test_addr_wrap();
        bytes_t body;
        bytes_t f;
        int d0, e0;
        d0 = done_seen;
        e0 = err_seen;
        body = {8'hFF, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        f = {8'hA5};
        foreach (body[i]) f.push_back(body[i]);
        f.push_back(xor_of(body));
        exp_q.push_back({16'hFFFF, 16'hAABB});
        exp_q.push_back({16'h0000, 16'hCCDD});
        send_bytes(f);
        exp_count = exp_count + 8'd1;
        repeat (2) @(negedge clk_in);
        checks++;
        if (done_seen - d0 !== 1 || err_seen - e0 !== 0) begin
            errors++;
            $display("FAIL wrap_pulses: got done=%0d err=%0d, expected done=1 err=0",
                     done_seen - d0, err_seen - e0);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL wrap_writes_missing: got %0d pending, expected 0", exp_q.size());
        end
        checks++;
        if (frame_count_out !== exp_count) begin
            errors++;
            $display("FAIL wrap_count: got %0d, expected %0d", frame_count_out, exp_count);
        end
    endtask

    task automatic test_timeout();
        int  k;
        bit  seen;
        int  e0;
        e0 = err_seen;
        send_byte(8'hA5);
        // The last byte is driven by hand so cycle counting starts at its accept edge.
        @(posedge clk_in); #1;
        byte_valid_in = 1'b1;
        byte_in       = 8'h00;
        @(posedge clk_in); #1;
        byte_valid_in = 1'b0;
        // Expiry is seen in the cycle at index TO, i.e. on the (TO+1)th falling edge.
        k    = 0;
        seen = 1'b0;
        while (k < 200 && !seen) begin
            @(negedge clk_in);
            k++;
            if (frame_error_out) seen = 1'b1;
        end
        checks++;
        if (!seen || k != TO + 1) begin
            errors++;
            $display("FAIL timeout_latency: got seen=%0d after %0d cycles, expected seen=1 at %0d",
                     seen, k, TO + 1);
        end
        repeat (3) @(negedge clk_in);
        checks++;
        if (err_seen - e0 !== 1) begin
            errors++;
            $display("FAIL timeout_pulses: got %0d error pulses, expected 1", err_seen - e0);
        end
        checks++;
        if (busy_out !== 1'b0 || frame_count_out !== exp_count) begin
            errors++;
            $display("FAIL timeout_idle: got busy=%b cnt=%0d, expected busy=0 cnt=%0d",
                     busy_out, frame_count_out, exp_count);
        end
        test_good_frame();
    endtask

    task automatic test_reset_mid_frame();
        bytes_t f;
        int d0, e0;
        d0 = done_seen;
        e0 = err_seen;
        f = {8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12};
        send_bytes(f);
        checks++;
        if (busy_out !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre_busy: got %b, expected 1", busy_out);
        end
        // Reset coincides with the byte that would otherwise complete a write.
        @(posedge clk_in); #1;
        rst_in        = 1'b1;
        byte_valid_in = 1'b1;
        byte_in       = 8'h34;
        @(posedge clk_in); #1;
        byte_valid_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if ({wr_en_out, wr_addr_out, wr_data_out, frame_done_out, frame_error_out,
             frame_count_out, busy_out} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got en=%b addr=%h data=%h done=%b err=%b cnt=%h busy=%b, expected all 0",
                     wr_en_out, wr_addr_out, wr_data_out, frame_done_out, frame_error_out,
                     frame_count_out, busy_out);
        end
        @(posedge clk_in); #1;
        rst_in    = 1'b0;
        exp_count = 8'd0;
        repeat (3) @(negedge clk_in);
        checks++;
        if (done_seen - d0 !== 0 || err_seen - e0 !== 0) begin
            errors++;
            $display("FAIL midreset_pulses: got done=%0d err=%0d, expected 0/0",
                     done_seen - d0, err_seen - e0);
        end
        test_good_frame();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_zero_len_garbage();
        test_addr_wrap();
        test_timeout();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

endmodule
